// File: rtl/cdc_toggle_req_tx.sv
// cdc_toggle_req_tx: source end of a toggle-handshake CDC; one word in flight at a time.
// Latency: accept -> req_tgl flips at the same edge; ack_tgl edge -> done = SYNC_STAGES+1 edges.
// Backpressure: s_ready low from the cycle after accept until the echoed ack has been synchronized.
//
// Captures a DATA_W word on s_valid & s_ready and holds it on req_data while
// the destination samples it. The request is signalled by flipping req_tgl.
// The destination echoes the toggle on ack_tgl, which is synchronized into
// inclk through a SYNC_STAGES flop chain before any use.
//
// Ports
//   inclk          source clock, all logic on posedge
//   areset_n       async active-low reset (release must be synchronous to inclk)
//   s_valid/s_ready/s_data   word offer handshake
//   req_data       captured word, stable from capture until done
//   req_tgl        request toggle, flips once per accepted word
//   ack_tgl        async echo of req_tgl from the destination domain
//   done           1-cycle pulse when the in-flight word has been acknowledged
//   busy           high while a word is in flight
//   timeout_pulse  1-cycle pulse when a transfer has waited TIMEOUT_CYC cycles
//   timeout_flag   sticky timeout indication, cleared by timeout_clr
//   timeout_clr    clears timeout_flag
//
// Build option: define CDC_TX_TIMEOUT_EN to include the wait-timeout monitor.
// Without it timeout_pulse/timeout_flag are tied low and timeout_clr is ignored.

module cdc_toggle_req_tx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,    // must be >= 2
  parameter int TIMEOUT_CYC = 1024  // must be >= 1
) (
  input  logic              inclk,
  input  logic              areset_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic [DATA_W-1:0] req_data,
  output logic              req_tgl,
  input  logic              ack_tgl,
  output logic              done,
  output logic              busy,
  output logic              timeout_pulse,
  output logic              timeout_flag,
  input  logic              timeout_clr
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DATA_W-1:0]      req_data_q, req_data_d;
  logic                   req_tgl_q, req_tgl_d;
  logic                   done_q, done_d;

  logic ack_s;    // synchronized ack toggle
  logic ack_eq;   // destination has caught up with the current request
  logic accept;   // word transfer at this edge

  // ------------------------------------------------------------------------
  // Ack synchronizer. ack_tgl only ever enters the first stage; everything
  // downstream looks at the last stage.
  // ------------------------------------------------------------------------
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], ack_tgl};
  end

  assign ack_s  = sync_q[SYNC_STAGES-1];
  assign ack_eq = (ack_s == req_tgl_q);

  // ------------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------------
  always_ff @(posedge inclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ------------------------------------------------------------------------
  // FSM: next state
  // ------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_WAIT;
      ST_WAIT: if (ack_eq) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------------
  // FSM: outputs. s_ready also requires ack_eq in IDLE so that a spurious
  // ack toggle from the destination stalls the source rather than letting a
  // new request race an out-of-step receiver. After the WAIT->IDLE edge the
  // toggles match, so s_ready is already high during the done cycle and a
  // held s_valid is taken at the edge that ends it.
  // ------------------------------------------------------------------------
  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b0;
    case (state_q)
      ST_IDLE: s_ready = ack_eq;
      ST_WAIT: busy    = 1'b1;
      default: begin
        s_ready = 1'b0;
        busy    = 1'b0;
      end
    endcase
  end

  assign accept = s_valid & s_ready;

  // ------------------------------------------------------------------------
  // Datapath. req_data and req_tgl only move on accept, which can only
  // happen in IDLE, so both are frozen for the whole WAIT period.
  // ------------------------------------------------------------------------
  always_comb begin
    req_data_d = req_data_q;
    req_tgl_d  = req_tgl_q;
    if (accept) begin
      req_data_d = s_data;
      req_tgl_d  = ~req_tgl_q;
    end
    // Leaving WAIT happens on exactly one edge, so done is a single pulse.
    done_d = (state_q == ST_WAIT) && ack_eq;
  end

  always_ff @(posedge inclk or negedge areset_n) begin
    if (!areset_n) begin
      sync_q     <= '0;
      req_data_q <= '0;
      req_tgl_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      req_data_q <= req_data_d;
      req_tgl_q  <= req_tgl_d;
      done_q     <= done_d;
    end
  end

  assign req_data = req_data_q;
  assign req_tgl  = req_tgl_q;
  assign done     = done_q;

`ifdef CDC_TX_TIMEOUT_EN
  // ------------------------------------------------------------------------
  // Wait-timeout monitor. Report only: it never alters the handshake.
  // The counter restarts on every accept and saturates at TIMEOUT_CYC, so
  // the pulse fires at most once per transfer. The pulse is registered and
  // appears in the cycle where the counter first holds TIMEOUT_CYC.
  // ------------------------------------------------------------------------
  localparam int              CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tpulse_q, tpulse_d;
  logic             tflag_q, tflag_d;

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = '0;
    end else if ((state_q == ST_WAIT) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end

    tpulse_d = (state_q == ST_WAIT) && !accept && (cnt_q == (CNT_MAX - 1'b1));

    // A new timeout beats a simultaneous clear so no event is lost.
    tflag_d = tflag_q;
    if (timeout_clr) tflag_d = 1'b0;
    if (tpulse_d)    tflag_d = 1'b1;
  end

  always_ff @(posedge inclk or negedge areset_n) begin
    if (!areset_n) begin
      cnt_q    <= '0;
      tpulse_q <= 1'b0;
      tflag_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      tpulse_q <= tpulse_d;
      tflag_q  <= tflag_d;
    end
  end

  assign timeout_pulse = tpulse_q;
  assign timeout_flag  = tflag_q;
`else
  logic unused_timeout_clr;
  assign unused_timeout_clr = timeout_clr;

  assign timeout_pulse = 1'b0;
  assign timeout_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_toggle_req_tx.sv
module tb_cdc_toggle_req_tx;

`ifdef CDC_TX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       inclk = 1'b0;
  logic       areset_n = 1'b0;
  logic       timeout_clr = 1'b0;

  // DUT A: SYNC_STAGES=2, TIMEOUT_CYC=16
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = 8'h00;
  logic [7:0] req_data;
  logic       req_tgl;
  logic       ack_tgl = 1'b0;
  logic       done, busy, timeout_pulse, timeout_flag;

  // DUT B: SYNC_STAGES=3
  logic       s_valid3 = 1'b0;
  logic       s_ready3;
  logic [7:0] s_data3 = 8'h00;
  logic [7:0] req_data3;
  logic       req_tgl3;
  logic       ack_tgl3 = 1'b0;
  logic       done3, busy3, timeout_pulse3, timeout_flag3;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 inclk = ~inclk;

  cdc_toggle_req_tx #(.DATA_W(8), .SYNC_STAGES(2), .TIMEOUT_CYC(16)) dut (
    .inclk(inclk), .areset_n(areset_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .req_data(req_data), .req_tgl(req_tgl), .ack_tgl(ack_tgl),
    .done(done), .busy(busy),
    .timeout_pulse(timeout_pulse), .timeout_flag(timeout_flag),
    .timeout_clr(timeout_clr)
  );

  cdc_toggle_req_tx #(.DATA_W(8), .SYNC_STAGES(3), .TIMEOUT_CYC(16)) dut3 (
    .inclk(inclk), .areset_n(areset_n),
    .s_valid(s_valid3), .s_ready(s_ready3), .s_data(s_data3),
    .req_data(req_data3), .req_tgl(req_tgl3), .ack_tgl(ack_tgl3),
    .done(done3), .busy(busy3),
    .timeout_pulse(timeout_pulse3), .timeout_flag(timeout_flag3),
    .timeout_clr(timeout_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge inclk);
    #1;
  endtask

  // Ticks until done (of the selected DUT) is seen; n = ticks taken, -1 if never.
  task automatic wait_done(input bit use3, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if ((use3 ? done3 : done) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int ndone, ntgl, word, stable_err, npulse, pulse_at, early_done;
    logic prev;

    // ---------------- reset values ----------------
    tick(); tick();
    chk("rst_req_tgl", req_tgl, 0);
    chk("rst_req_data", req_data, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tpulse", timeout_pulse, 0);
    chk("rst_tflag", timeout_flag, 0);
    areset_n = 1'b1;
    tick();
    chk("rst_s_ready", s_ready, 1);

    // ---------------- test 4: reset mid-WAIT ----------------
    s_data = 8'h5A; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    chk("t4_busy", busy, 1);
    chk("t4_req_tgl", req_tgl, 1);
    chk("t4_req_data", req_data, 8'h5A);
    tick();
    areset_n = 1'b0;
    #1;
    chk("t4_async_req_tgl", req_tgl, 0);
    chk("t4_async_req_data", req_data, 0);
    chk("t4_async_busy", busy, 0);
    early_done = 0;
    tick(); if (done) early_done++;
    tick(); if (done) early_done++;
    areset_n = 1'b1;
    tick(); if (done) early_done++;
    tick(); if (done) early_done++;
    chk("t4_no_done", early_done, 0);
    chk("t4_s_ready", s_ready, 1);

    // ---------------- test 5: spurious ack in IDLE ----------------
    ack_tgl = 1'b1;
    tick();
    chk("t5_ready_1", s_ready, 1);
    tick();
    chk("t5_ready_drop", s_ready, 0);
    s_valid = 1'b1; s_data = 8'hEE;
    early_done = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) early_done++;
    end
    s_valid = 1'b0;
    chk("t5_no_done", early_done, 0);
    chk("t5_no_accept", req_tgl, 0);
    chk("t5_busy", busy, 0);
    ack_tgl = 1'b0;
    tick();
    chk("t5_still_low", s_ready, 0);
    tick();
    chk("t5_ready_back", s_ready, 1);

    // ---------------- test 1: single transfer ----------------
    s_data = 8'hA5; s_valid = 1'b1;
    tick();
    s_valid = 1'b0; s_data = 8'h00;
    chk("t1_req_tgl", req_tgl, 1);
    chk("t1_req_data", req_data, 8'hA5);
    chk("t1_s_ready_low", s_ready, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("t1_held", req_data, 8'hA5);
    chk("t1_no_early_done", done, 0);
    ack_tgl = 1'b1;
    wait_done(1'b0, 10, n);
    chk("t1_latency", n, 3);
    chk("t1_s_ready_back", s_ready, 1);
    chk("t1_busy_low", busy, 0);
    tick();
    chk("t1_done_1cyc", done, 0);

    // ---------------- test 2: back-to-back with loopback ack ----------------
    s_data = 8'h01; s_valid = 1'b1;
    word = 1; ndone = 0; ntgl = 0; stable_err = 0; prev = req_tgl;
    for (int i = 0; i < 100 && ndone < 4; i++) begin
      tick();
      ack_tgl = req_tgl;
      if (req_tgl !== prev) begin
        ntgl++;
        prev = req_tgl;
      end
      if (busy && req_data !== word[7:0]) stable_err++;
      if (done) begin
        chk("t2_word", req_data, word);
        ndone++;
        word++;
        if (word <= 4) s_data = word[7:0];
        else s_valid = 1'b0;
      end
    end
    s_valid = 1'b0;
    chk("t2_done_cnt", ndone, 4);
    chk("t2_tgl_cnt", ntgl, 4);
    chk("t2_stable", stable_err, 0);

    // ---------------- test 3: SYNC_STAGES=3 ----------------
    s_data3 = 8'h3C; s_valid3 = 1'b1;
    chk("t3_ready", s_ready3, 1);
    tick();
    s_valid3 = 1'b0; s_data3 = 8'hC3;
    chk("t3_busy", busy3, 1);
    chk("t3_req_tgl", req_tgl3, 1);
    tick(); tick(); tick();
    chk("t3_held", req_data3, 8'h3C);
    ack_tgl3 = 1'b1;
    wait_done(1'b1, 10, n);
    chk("t3_latency", n, 4);
    chk("t3_held_at_done", req_data3, 8'h3C);
    chk("t3_ready_back", s_ready3, 1);

    // ---------------- test 6: timeout ----------------
    s_data = 8'h77; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    chk("t6_busy", busy, 1);
    npulse = 0; pulse_at = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (timeout_pulse) begin
        npulse++;
        if (pulse_at < 0) pulse_at = i;
      end
      if (i == 15) chk("t6_flag_before", timeout_flag, 0);
      if (done) early_done++;
    end
    chk("t6_pulse_cnt", npulse, TO_EN ? 1 : 0);
    chk("t6_pulse_at", pulse_at, TO_EN ? 16 : -1);
    chk("t6_flag_set", timeout_flag, TO_EN ? 1 : 0);
    chk("t6_still_busy", busy, 1);
    ack_tgl = req_tgl;
    wait_done(1'b0, 10, n);
    chk("t6_late_done", n, 3);
    chk("t6_flag_after_done", timeout_flag, TO_EN ? 1 : 0);
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    chk("t6_flag_clr", timeout_flag, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
